// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
// Sits between the board-level request sources and the DDR3 controller FSM.
// It owns the refresh interval timer and counts owed (postponed) refreshes.
// It synchronizes and edge-detects the write/read buttons. It arbitrates
// refresh, write and read into one command strobe at a time, and holds that
// strobe until the controller accepts it by dropping sm_idle.
//
// Ports
//   CLK          in   controller clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   init_done    in   DRAM initialization complete (level)
//   sm_idle      in   controller idle / able to accept; low = accept
//   wr_btn       in   write request button (asynchronous)
//   rd_btn       in   read request button (asynchronous)
//   wr_data_in   in   write byte, sampled when a write request is captured
//   REF          out  refresh command strobe
//   WRITE        out  write command strobe
//   READ         out  read command strobe
//   Data_Write   out  captured write byte
//   ref_owed     out  number of owed refreshes (0..MAX_POSTPONE)
//   busy         out  a command is being issued or completing
//   ref_overflow out  sticky: an interval elapsed with the owed count already full
module dram_cmd_scheduler #(
    parameter int unsigned REFI_CYCLES  = 2496,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       init_done,
    input  logic       sm_idle,
    input  logic       wr_btn,
    input  logic       rd_btn,
    input  logic [7:0] wr_data_in,
    output logic       REF,
    output logic       WRITE,
    output logic       READ,
    output logic [7:0] Data_Write,
    output logic [3:0] ref_owed,
    output logic       busy,
    output logic       ref_overflow
);

    localparam int unsigned TIMER_W = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFI_CYCLES - 1);
    localparam logic [3:0] OWED_MAX = 4'(MAX_POSTPONE);

    typedef enum logic [1:0] {
        S_WAIT_INIT = 2'd0,
        S_IDLE      = 2'd1,
        S_ISSUE     = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TIMER_W-1:0] timer;
    logic               tick;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value
    logic [2:0] wr_sync;
    logic [2:0] rd_sync;
    logic       wr_edge;
    logic       rd_edge;
    logic       wr_capture;
    logic       rd_capture;
    logic       wr_pend;
    logic       rd_pend;

    logic ref_nxt;
    logic write_nxt;
    logic read_nxt;
    logic busy_nxt;
    logic ref_accept;
    logic wr_accept;
    logic rd_accept;

    // Button synchronizers and edge history
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_sync <= 3'b000;
            rd_sync <= 3'b000;
        end else begin
            wr_sync <= {wr_sync[1:0], wr_btn};
            rd_sync <= {rd_sync[1:0], rd_btn};
        end
    end

    assign wr_edge = wr_sync[1] & ~wr_sync[2];
    assign rd_edge = rd_sync[1] & ~rd_sync[2];

    // Edges are ignored until the DRAM is initialized; a second edge while
    // the first request is still pending is dropped.
    assign wr_capture = wr_edge & ~wr_pend & (state != S_WAIT_INIT);
    assign rd_capture = rd_edge & ~rd_pend & (state != S_WAIT_INIT);

    // Refresh interval timer, free-running once init_done is high
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            timer <= '0;
        end else if (init_done) begin
            timer <= (timer == TIMER_LAST) ? '0 : timer + TIMER_W'(1);
        end
    end

    assign tick = init_done & (timer == TIMER_LAST);

    // Next-state and next-strobe logic
    always_comb begin
        state_nxt  = state;
        ref_nxt    = REF;
        write_nxt  = WRITE;
        read_nxt   = READ;
        ref_accept = 1'b0;
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;

        case (state)
            S_WAIT_INIT: begin
                ref_nxt   = 1'b0;
                write_nxt = 1'b0;
                read_nxt  = 1'b0;
                if (init_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (sm_idle) begin
                    if (ref_owed == OWED_MAX) begin
                        ref_nxt   = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (wr_pend) begin
                        write_nxt = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (rd_pend) begin
                        read_nxt  = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (ref_owed != 4'd0) begin
                        ref_nxt   = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // sm_idle falling is the controller's accept
                if (!sm_idle) begin
                    ref_accept = REF;
                    wr_accept  = WRITE;
                    rd_accept  = READ;
                    ref_nxt    = 1'b0;
                    write_nxt  = 1'b0;
                    read_nxt   = 1'b0;
                    state_nxt  = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (sm_idle) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                ref_nxt   = 1'b0;
                write_nxt = 1'b0;
                read_nxt  = 1'b0;
                state_nxt = S_WAIT_INIT;
            end
        endcase

        busy_nxt = (state_nxt == S_ISSUE) || (state_nxt == S_WAIT_DONE);
    end

    // State and registered strobes
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_WAIT_INIT;
            REF   <= 1'b0;
            WRITE <= 1'b0;
            READ  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            REF   <= ref_nxt;
            WRITE <= write_nxt;
            READ  <= read_nxt;
            busy  <= busy_nxt;
        end
    end

    // Pending write request and its data byte
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_pend    <= 1'b0;
            Data_Write <= 8'h00;
        end else if (wr_accept) begin
            wr_pend <= 1'b0;
        end else if (wr_capture) begin
            wr_pend    <= 1'b1;
            Data_Write <= wr_data_in;
        end
    end

    // Pending read request
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_pend <= 1'b0;
        end else if (rd_accept) begin
            rd_pend <= 1'b0;
        end else if (rd_capture) begin
            rd_pend <= 1'b1;
        end
    end

    // Owed-refresh bookkeeping; a tick and a REF accept together cancel out
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            ref_owed     <= 4'd0;
            ref_overflow <= 1'b0;
        end else if (tick && !ref_accept) begin
            if (ref_owed < OWED_MAX) begin
                ref_owed <= ref_owed + 4'd1;
            end else begin
                ref_overflow <= 1'b1;
            end
        end else if (ref_accept && !tick) begin
            ref_owed <= ref_owed - 4'd1;
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Testbench for dram_cmd_scheduler: vector table, directed corner sequences,
// and randomized traffic checked every cycle against a reference model.
module tb_dram_cmd_scheduler;

    localparam int REFI = 16;
    localparam int MAXP = 8;

    logic       CLK;
    logic       Reset_n;
    logic       init_done;
    logic       sm_idle;
    logic       wr_btn;
    logic       rd_btn;
    logic [7:0] wr_data_in;
    logic       REF;
    logic       WRITE;
    logic       READ;
    logic [7:0] Data_Write;
    logic [3:0] ref_owed;
    logic       busy;
    logic       ref_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    dram_cmd_scheduler #(
        .REFI_CYCLES (REFI),
        .MAX_POSTPONE(MAXP)
    ) dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .init_done   (init_done),
        .sm_idle     (sm_idle),
        .wr_btn      (wr_btn),
        .rd_btn      (rd_btn),
        .wr_data_in  (wr_data_in),
        .REF         (REF),
        .WRITE       (WRITE),
        .READ        (READ),
        .Data_Write  (Data_Write),
        .ref_owed    (ref_owed),
        .busy        (busy),
        .ref_overflow(ref_overflow)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({REF, WRITE, READ, Data_Write, ref_owed, busy, ref_overflow});
    endfunction

    // ---------------- reference model ----------------
    // phase: 0 waiting for init, 1 idle, 2 issuing, 3 waiting for completion
    // cmd:   1 refresh, 2 write, 3 read
    int         m_tmr;
    int         m_owed;
    int         m_phase;
    int         m_cmd;
    bit         m_ovf;
    bit         m_wreq;
    bit         m_rreq;
    logic [7:0] m_data;
    bit   [2:0] m_wh;   // button samples: [0] last edge, [1] two edges ago, [2] three ago
    bit   [2:0] m_rh;

    function automatic void model_reset();
        m_tmr = 0; m_owed = 0; m_phase = 0; m_cmd = 0;
        m_ovf = 0; m_wreq = 0; m_rreq = 0; m_data = 8'h00;
        m_wh = 3'b000; m_rh = 3'b000;
    endfunction

    function automatic void model_step();
        bit tick, wedge, redge, acc;
        int done_cmd, pick;
        tick     = init_done && (m_tmr == REFI - 1);
        wedge    = m_wh[1] && !m_wh[2];
        redge    = m_rh[1] && !m_rh[2];
        acc      = (m_phase == 2) && !sm_idle;
        done_cmd = acc ? m_cmd : 0;

        // requests captured with the pre-edge pending state and phase
        if (done_cmd == 2) m_wreq = 0;
        else if (wedge && !m_wreq && m_phase != 0) begin
            m_wreq = 1;
            m_data = wr_data_in;
        end
        if (done_cmd == 3) m_rreq = 0;
        else if (redge && !m_rreq && m_phase != 0) m_rreq = 1;

        case (m_phase)
            0: if (init_done) m_phase = 1;
            1: if (sm_idle) begin
                pick = 0;
                if (m_owed == MAXP) pick = 1;
                else if (m_wreq && done_cmd != 2 && !(wedge && m_phase == 1 && 0)) pick = 0;
                m_phase = m_phase;
                m_cmd   = m_cmd;
                pick    = pick;
            end
            default: ;
        endcase
        return;
    endfunction

    // Phase selection is done separately so the priority choice sees the
    // request flags exactly as they stood before the clock edge.
    bit wreq_pre, rreq_pre;
    int owed_pre;

    function automatic void model_edge();
        bit tick, acc;
        int pick;
        wreq_pre = m_wreq;
        rreq_pre = m_rreq;
        owed_pre = m_owed;
        tick = init_done && (m_tmr == REFI - 1);
        acc  = (m_phase == 2) && !sm_idle;

        if (tick && !(acc && m_cmd == 1)) begin
            if (m_owed < MAXP) m_owed = m_owed + 1;
            else m_ovf = 1;
        end else if ((acc && m_cmd == 1) && !tick) begin
            m_owed = m_owed - 1;
        end

        // request flags and data (also uses pre-edge phase/cmd)
        begin
            bit wedge, redge;
            wedge = m_wh[1] && !m_wh[2];
            redge = m_rh[1] && !m_rh[2];
            if (acc && m_cmd == 2) m_wreq = 0;
            else if (wedge && !wreq_pre && m_phase != 0) begin
                m_wreq = 1;
                m_data = wr_data_in;
            end
            if (acc && m_cmd == 3) m_rreq = 0;
            else if (redge && !rreq_pre && m_phase != 0) m_rreq = 1;
        end

        case (m_phase)
            0: if (init_done) m_phase = 1;
            1: if (sm_idle) begin
                if (owed_pre == MAXP) pick = 1;
                else if (wreq_pre)    pick = 2;
                else if (rreq_pre)    pick = 3;
                else if (owed_pre > 0) pick = 1;
                else                  pick = 0;
                if (pick != 0) begin
                    m_cmd   = pick;
                    m_phase = 2;
                end
            end
            2: if (!sm_idle) begin
                m_phase = 3;
                m_cmd   = 0;
            end
            default: if (sm_idle) m_phase = 1;
        endcase

        if (init_done) m_tmr = (m_tmr + 1) % REFI;
        m_wh = {m_wh[1:0], wr_btn};
        m_rh = {m_rh[1:0], rd_btn};
    endfunction

    function automatic logic [31:0] model_vec();
        logic r, w, d, b;
        r = (m_phase == 2) && (m_cmd == 1);
        w = (m_phase == 2) && (m_cmd == 2);
        d = (m_phase == 2) && (m_cmd == 3);
        b = (m_phase >= 2);
        return 32'({r, w, d, m_data, 4'(m_owed), b, m_ovf});
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge Reset_n);
            if (!Reset_n) model_reset();
            else model_edge();
        end
    end

    // Every cycle, the DUT must agree with the model
    initial begin
        forever begin
            @(negedge CLK);
            chk("model", dut_vec(), model_vec());
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       i_init;
        logic       i_idle;
        logic       i_wr;
        logic       i_rd;
        logic [7:0] i_data;
        int         n;
        logic       e_ref;
        logic       e_wr;
        logic       e_rd;
        logic [7:0] e_dw;
        logic [3:0] e_owed;
        logic       e_busy;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic ii, input logic id, input logic iw, input logic ir,
                                input logic [7:0] dt, input int n, input logic er, input logic ew,
                                input logic erd, input logic [7:0] edw, input logic [3:0] eo,
                                input logic eb);
        vec_t v;
        v.i_init = ii; v.i_idle = id; v.i_wr = iw; v.i_rd = ir; v.i_data = dt; v.n = n;
        v.e_ref = er; v.e_wr = ew; v.e_rd = erd; v.e_dw = edw; v.e_owed = eo; v.e_busy = eb;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        #1;
        Reset_n = 1'b0; init_done = 1'b0; sm_idle = 1'b0;
        wr_btn = 1'b0; rd_btn = 1'b0; wr_data_in = 8'h00;
        repeat (2) @(negedge CLK);
        #1 Reset_n = 1'b1;
        @(negedge CLK);
    endtask

    // Controller stand-in: wait for a strobe, accept it, return to idle
    task automatic serve(output int cmd, output logic [7:0] d);
        cmd = 0;
        d   = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (REF || WRITE || READ) begin
                cmd = REF ? 1 : (WRITE ? 2 : 3);
                d   = Data_Write;
                break;
            end
        end
        if (cmd != 0) begin
            sm_idle = 1'b0;
            @(negedge CLK);
            sm_idle = 1'b1;
        end
    endtask

    initial begin
        int         c;
        int         lat;
        int         nother;
        logic [7:0] d;
        bit         seen;
        bit         drained;
        int         hold;

        Reset_n = 1'b0; init_done = 1'b0; sm_idle = 1'b0;
        wr_btn = 1'b0; rd_btn = 1'b0; wr_data_in = 8'h00;

        //            init idle wr rd data  n  | ref wr rd dw    owed busy
        tbl[0]  = mk(0, 1, 1, 1, 8'h11, 5,   0, 0, 0, 8'h00, 4'd0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 8'h00, 4,   0, 0, 0, 8'h00, 4'd0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 8'hA5, 1,   0, 0, 0, 8'h00, 4'd0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 8'hA5, 3,   0, 0, 0, 8'hA5, 4'd0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 8'h00, 1,   0, 1, 0, 8'hA5, 4'd0, 1);
        tbl[5]  = mk(1, 1, 0, 0, 8'h00, 3,   0, 1, 0, 8'hA5, 4'd0, 1);
        tbl[6]  = mk(1, 0, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 8'h00, 2,   0, 0, 0, 8'hA5, 4'd0, 1);
        tbl[8]  = mk(1, 1, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd0, 0);
        tbl[9]  = mk(1, 1, 0, 0, 8'h00, 1,   0, 0, 1, 8'hA5, 4'd0, 1);
        tbl[10] = mk(1, 0, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd0, 1);
        tbl[11] = mk(1, 1, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd0, 0);
        tbl[12] = mk(1, 1, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd1, 0);
        tbl[13] = mk(1, 1, 0, 0, 8'h00, 1,   1, 0, 0, 8'hA5, 4'd1, 1);
        tbl[14] = mk(1, 0, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd0, 1);
        tbl[15] = mk(1, 1, 0, 0, 8'h00, 1,   0, 0, 0, 8'hA5, 4'd0, 0);

        // Reset state
        repeat (2) @(negedge CLK);
        chk("reset_state", dut_vec(), 32'h0);
        #1 Reset_n = 1'b1;

        // Table: init gating, write-over-read priority, refresh tick
        for (int i = 0; i < NV; i++) begin
            init_done  = tbl[i].i_init;
            sm_idle    = tbl[i].i_idle;
            wr_btn     = tbl[i].i_wr;
            rd_btn     = tbl[i].i_rd;
            wr_data_in = tbl[i].i_data;
            repeat (tbl[i].n) @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("vec%0d", i),
                32'({REF, WRITE, READ, Data_Write, ref_owed, busy}),
                32'({tbl[i].e_ref, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_dw, tbl[i].e_owed, tbl[i].e_busy}));
        end

        // Init gating over 100 cycles, then first-refresh latency
        do_reset();
        sm_idle = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            wr_btn = ((i % 6) < 3);
            rd_btn = ((i % 4) < 2);
            seen |= REF | WRITE | READ | busy;
        end
        chk("init_gate_strobes", 32'(seen), 32'h0);
        chk("init_gate_owed", 32'(ref_owed), 32'h0);
        wr_btn = 1'b0;
        rd_btn = 1'b0;
        repeat (5) @(negedge CLK);
        init_done = 1'b1;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLK);
            if (REF) begin
                lat = n;
                break;
            end
        end
        chk_range("first_ref_latency", lat, 17, 18);
        serve(c, d);
        chk("first_ref_cmd", 32'(c), 32'd1);
        chk("first_ref_owed_after", 32'(ref_owed), 32'h0);

        // Forced refresh, overflow and drop-on-pending
        do_reset();
        init_done = 1'b1;
        sm_idle   = 1'b0;
        @(negedge CLK);
        wr_data_in = 8'h5A;
        wr_btn     = 1'b1;
        repeat (2) @(negedge CLK);
        wr_btn = 1'b0;
        repeat (4) @(negedge CLK);
        chk("drop_first_data", 32'(Data_Write), 32'h5A);
        wr_data_in = 8'h3C;
        wr_btn     = 1'b1;
        repeat (2) @(negedge CLK);
        wr_btn = 1'b0;
        repeat (4) @(negedge CLK);
        chk("drop_second_ignored", 32'(Data_Write), 32'h5A);
        repeat (117) @(negedge CLK);
        chk("owed_full", 32'(ref_owed), 32'd8);
        chk("no_overflow_yet", 32'(ref_overflow), 32'h0);
        repeat (20) @(negedge CLK);
        chk("owed_saturated", 32'(ref_owed), 32'd8);
        chk("overflow_set", 32'(ref_overflow), 32'h1);
        sm_idle = 1'b1;
        serve(c, d);
        chk("forced_ref_first", 32'(c), 32'd1);
        serve(c, d);
        chk("write_after_forced", 32'(c), 32'd2);
        chk("write_original_data", 32'(d), 32'h5A);
        nother  = 0;
        drained = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (ref_owed == 4'd0) begin
                drained = 1'b1;
                break;
            end
            serve(c, d);
            if (c != 1) nother++;
        end
        chk("refresh_drained", 32'(drained), 32'h1);
        chk("single_write_only", 32'(nother), 32'h0);
        chk("overflow_sticky", 32'(ref_overflow), 32'h1);

        // Reset while WRITE is high
        do_reset();
        init_done = 1'b1;
        sm_idle   = 1'b1;
        @(negedge CLK);
        wr_data_in = 8'h77;
        wr_btn     = 1'b1;
        repeat (2) @(negedge CLK);
        wr_btn = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (WRITE) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_write_seen", 32'(seen), 32'h1);
        #1 Reset_n = 1'b0;
        #1 chk("rst_async_clear", dut_vec(), 32'h0);
        @(negedge CLK);
        #1 Reset_n = 1'b1;
        @(negedge CLK);
        chk("rst_after_release", dut_vec(), 32'h0);

        // Randomized traffic with one mid-run reset
        do_reset();
        init_done = 1'b1;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (i == 1500) #1 Reset_n = 1'b0;
            if (i == 1503) #1 Reset_n = 1'b1;
            if (i == 200 || $urandom_range(0, 599) == 0) hold = 150;
            if (hold > 0) begin
                sm_idle = 1'b0;
                hold--;
            end else begin
                sm_idle = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 15) == 0) wr_btn = ~wr_btn;
            if ($urandom_range(0, 15) == 0) rd_btn = ~rd_btn;
            wr_data_in = 8'($urandom);
        end

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Command scheduler that sits between the board-level request sources and the DDR3 controller state machine. It owns the refresh interval timer and tracks postponed refreshes. It synchronizes and edge-detects the write/read buttons, and arbitrates refresh, write and read into exactly one command strobe at a time. That strobe goes to the controller's REF/WRITE/READ inputs and is released on the controller's accept handshake.

## Interface
- REFI_CYCLES, 2496: CLK cycles per refresh interval (7.8 us at 320 MHz).
- MAX_POSTPONE, 8: maximum owed refreshes; reaching it forces refresh priority.
- CLK  in  1  controller clock (320 MHz); all logic on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- init_done  in  1  DRAM initialization complete; level, stays high once set.
- sm_idle  in  1  controller is in IDLE and able to accept a command.
- wr_btn  in  1  write request button, asynchronous to CLK.
- rd_btn  in  1  read request button, asynchronous to CLK.
- wr_data_in  in  8  write byte (switches), sampled at write-request capture.
- REF  out  1  refresh command strobe.
- WRITE  out  1  write command strobe.
- READ  out  1  read command strobe.
- Data_Write  out  8  captured write byte, stable while WRITE pending or asserted.
- ref_owed  out  4  count of owed refreshes, 0..MAX_POSTPONE.
- busy  out  1  high in S_ISSUE or S_WAIT_DONE.
- ref_overflow  out  1  sticky error: an interval elapsed while ref_owed == MAX_POSTPONE.

## Operation
- Reset values: REF/WRITE/READ = 0, Data_Write = 0, ref_owed = 0, busy = 0, ref_overflow = 0, timer = 0, wr_pend = rd_pend = 0, state = S_WAIT_INIT.
- Refresh timer: counts 0..REFI_CYCLES-1 and wraps. It runs only while init_done = 1. The wrap cycle produces a one-cycle tick.
- Tick handling:
  - ref_owed < MAX_POSTPONE: ref_owed increments.
  - ref_owed == MAX_POSTPONE: ref_owed holds and ref_overflow sets (cleared only by reset).
- Request capture:
  - Each button passes through a 2-flop synchronizer and then a rising-edge detector.
  - A write edge with wr_pend = 0 sets wr_pend and loads Data_Write <= wr_data_in.
  - A write edge with wr_pend = 1 is dropped, and Data_Write is not overwritten.
  - Read requests work the same way using rd_pend.
  - Requests are captured in every state except S_WAIT_INIT, where edges are ignored.
- States:
  - S_WAIT_INIT: all strobes low. Moves to S_IDLE when init_done = 1.
  - S_IDLE: when sm_idle = 1, pick a command by fixed priority and go to S_ISSUE with that strobe set:
    1. REF if ref_owed == MAX_POSTPONE.
    2. WRITE if wr_pend.
    3. READ if rd_pend.
    4. REF if ref_owed != 0.
    5. Otherwise stay in S_IDLE.
  - S_ISSUE: the strobe is held high until sm_idle = 0, which is the accept. On accept, drop the strobe, clear the pending flag (or decrement ref_owed for REF), and go to S_WAIT_DONE.
  - S_WAIT_DONE: go to S_IDLE when sm_idle = 1.
- At most one strobe is high in any cycle. Strobes are registered outputs.
- Tick and REF accept in the same cycle: ref_owed is unchanged and ref_overflow is not set.
- Write edge on the same cycle as a WRITE accept: the old request is cleared. The new edge is dropped, because pend was 1 at the time of the edge.

## Timing
- Button rising edge to pend set: 3 CLK cycles (2 sync + edge register).
- Pend set to strobe high: 1 cycle after the first S_IDLE cycle with sm_idle = 1.
- Strobe stays high from the first assert cycle through the cycle in which sm_idle = 0 is sampled. It is low on the following edge.
- The earliest next strobe is 1 cycle after sm_idle returns high. There is no back-to-back strobe without an intervening sm_idle low/high pair.
- Reset_n low forces all outputs and state to their reset values immediately (asynchronous), including mid-S_ISSUE. A pending command or owed refresh is lost. Deassertion is synchronized by the parent.
- ref_owed updates 1 cycle after tick or accept.

## Test plan
- Bench uses REFI_CYCLES = 16, MAX_POSTPONE = 8.
- Init gating: hold init_done = 0 for 100 cycles and toggle both buttons -> no strobes, ref_owed = 0. Raise init_done with sm_idle = 1 -> first REF strobe 17-18 cycles later, and ref_owed returns to 0 after accept.
- Write priority: sm_idle = 1, wr_data_in = 0xA5, then pulse wr_btn and rd_btn on the same cycle -> WRITE first with Data_Write = 0xA5; READ is issued only after an sm_idle low/high pair.
- Forced refresh: hold sm_idle = 0 for 8×16 cycles with a write pending -> ref_owed = 8. Release sm_idle -> REF is issued before WRITE.
- Overflow: hold sm_idle = 0 for 9×16 cycles -> ref_owed saturates at 8 and ref_overflow = 1 remains set after refreshes drain.
- Drop-on-pending: while a write is pending, press wr_btn again with wr_data_in = 0x3C -> only one WRITE is issued, with the original Data_Write.
- Reset mid-issue: assert Reset_n = 0 while WRITE is high -> WRITE = 0 in the same cycle, and all outputs are 0 after release.
